// File: rtl/huffman_pkg.sv
// huffman_pkg: shared state encoding and code-table field helpers for the stream packer
package huffman_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   function automatic int entry_w(input int len_w, input int max_len);
      return len_w + max_len;
   endfunction

   function automatic logic [31:0] len_of(input logic [31:0] entry, input int max_len);
      return entry >> max_len;
   endfunction

   function automatic logic [31:0] code_of(input logic [31:0] entry, input int max_len);
      return entry & ((32'd1 << max_len) - 32'd1);
   endfunction

endpackage

// File: rtl/huffman_code_lookup.sv
// huffman_code_lookup: combinational table lookup mapping a symbol to {len, code, bad}
module huffman_code_lookup import huffman_pkg::*; #(
   parameter int NUM_SYMS = 10,
   parameter int MAX_LEN  = 9,
   parameter int LEN_W    = 4,
   parameter int SYM_W    = 4,
   parameter int E        = entry_w(LEN_W, MAX_LEN)
) (
   input  logic [NUM_SYMS*E-1:0] code_table,
   input  logic [SYM_W-1:0]      sym,
   output logic [LEN_W-1:0]      len,
   output logic [MAX_LEN-1:0]    code,
   output logic                  bad
);

   logic [E-1:0] ent [NUM_SYMS];
   logic [E-1:0] entry;
   logic         ok;

   for (genvar i = 0; i < NUM_SYMS; i++) begin : g_ent
      assign ent[i] = code_table[i*E +: E];
   end

   // pick the entry and flag out-of-range symbols or unusable lengths
   always_comb begin
      ok    = 32'(sym) < NUM_SYMS;
      entry = ok ? ent[sym] : '0;
      len   = LEN_W'(len_of(32'(entry), MAX_LEN));
      code  = MAX_LEN'(code_of(32'(entry), MAX_LEN));
      bad   = !ok || len == '0 || 32'(len) > MAX_LEN;
   end

endmodule

// File: rtl/huffman_stream_packer.sv
// huffman_stream_packer: packs table-coded symbols MSB-first into framed output words
module huffman_stream_packer import huffman_pkg::*; #(
   parameter int NUM_SYMS = 10,
   parameter int MAX_LEN  = 9,
   parameter int LEN_W    = 4,
   parameter int OUT_W    = 32,
   parameter int CNT_W    = 16,
   parameter int SYM_W    = 4
) (
   input  logic                                 CLK,
   input  logic                                 nRST,
   input  logic [NUM_SYMS*(LEN_W+MAX_LEN)-1:0]  CODE_TABLE,
   input  logic                                 sym_valid,
   output logic                                 sym_ready,
   input  logic [SYM_W-1:0]                     sym_data,
   input  logic                                 sym_last,
   output logic                                 word_valid,
   input  logic                                 word_ready,
   output logic [OUT_W-1:0]                     word_data,
   output logic [$clog2(OUT_W+1)-1:0]           word_bits,
   output logic                                 word_last,
   output logic [CNT_W-1:0]                     bit_count,
   output logic                                 done,
   output logic                                 busy,
   output logic                                 err
);

   localparam int E  = entry_w(LEN_W, MAX_LEN);
   localparam int AW = OUT_W + MAX_LEN;
   localparam int FW = $clog2(AW + 1);
   localparam int BW = $clog2(OUT_W + 1);
   localparam logic [FW-1:0] OUT_F = FW'(OUT_W);

   state_t              state_q, state_d;
   logic [NUM_SYMS*E-1:0] tbl_q, tbl_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [FW-1:0]       fill_q, fill_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                wv_q, wv_d;
   logic [OUT_W-1:0]    wdata_q, wdata_d;
   logic [BW-1:0]       wbits_q, wbits_d;
   logic                wlast_q, wlast_d;

   logic [LEN_W-1:0]    len, len_eff;
   logic [MAX_LEN-1:0]  code;
   logic                bad, accept, pop;
   logic [AW-1:0]       cw;
   logic [CNT_W-1:0]    cnt_base;
   logic [CNT_W:0]      sum;

   huffman_code_lookup #(
      .NUM_SYMS(NUM_SYMS), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .SYM_W(SYM_W)
   ) u_lookup (
      .code_table(tbl_q), .sym(sym_data), .len(len), .code(code), .bad(bad)
   );

   assign sym_ready  = (state_q == IDLE || state_q == RUN) && fill_q < OUT_F;
   assign word_valid = wv_q;
   assign word_data  = wdata_q;
   assign word_bits  = wbits_q;
   assign word_last  = wlast_q;
   assign bit_count  = cnt_q;
   assign err        = err_q;
   assign done       = state_q == DONE;
   assign busy       = state_q != IDLE;

   // next state: append accepted codes, drain emitted words, and precompute the next output word
   always_comb begin
      accept   = sym_valid && sym_ready;
      pop      = wv_q && word_ready;
      len_eff  = bad ? '0 : len;
      cw       = AW'(code) & ((AW'(1) << len_eff) - AW'(1));
      cnt_base = state_q == IDLE ? '0 : cnt_q;
      sum      = {1'b0, cnt_base} + (CNT_W+1)'(len_eff);
      state_d  = state_q;
      tbl_d    = state_q == IDLE ? CODE_TABLE : tbl_q;
      acc_d    = acc_q;
      fill_d   = fill_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      if (accept) begin
         acc_d   = acc_q | (cw << (FW'(AW) - fill_q - FW'(len_eff)));
         fill_d  = fill_q + FW'(len_eff);
         cnt_d   = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
         err_d   = (state_q != IDLE && err_q) || bad;
         state_d = sym_last ? FLUSH : RUN;
      end
      if (pop) begin
         acc_d   = acc_q << OUT_W;
         fill_d  = fill_q - FW'(wbits_q);
         state_d = wlast_q ? DONE : state_q;
      end
      if (state_q == DONE) state_d = IDLE;
      wv_d    = state_d == FLUSH || (state_d == RUN && fill_d >= OUT_F);
      wlast_d = state_d == FLUSH && fill_d <= OUT_F;
      wbits_d = !wv_d ? '0 : wlast_d ? BW'(fill_d) : BW'(OUT_W);
      wdata_d = wv_d ? acc_d[AW-1 -: OUT_W] : '0;
   end

   // state and output registers, cleared immediately by reset
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         tbl_q   <= '0;
         acc_q   <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         wv_q    <= 1'b0;
         wdata_q <= '0;
         wbits_q <= '0;
         wlast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tbl_q   <= tbl_d;
         acc_q   <= acc_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         wv_q    <= wv_d;
         wdata_q <= wdata_d;
         wbits_q <= wbits_d;
         wlast_q <= wlast_d;
      end
   end

endmodule
